// File: rtl/mem_request_unit.sv
// mem_request_unit
//
// Request unit between the control unit / PC and the I/D cache ports.
// Latches a data-memory request on an instruction hit and holds it until the
// data cache acknowledges it. A halt seen while a data request is outstanding
// is deferred until that request drains. PC writes are gated so the PC only
// advances when the current instruction has fully completed.
//
// Parameters:
//   WAIT_W              width of the data-stall counter
//   MAX_WAIT            stall count at which timeout asserts (1 .. 2**WAIT_W-1)
//   IFETCH_DURING_DATA  1: keep imemREN high while a data request is pending
//                       0: drop imemREN while a data request is pending
//
// Ports:
//   CLK        system clock, rising edge
//   nRST       asynchronous active-low reset
//   halt       halt decoded by the control unit
//   dREN/dWEN  current instruction reads / writes data memory
//   ihit/dhit  instruction cache hit / data cache acknowledge
//   dmemREN    registered data read request
//   dmemWEN    registered data write request
//   imemREN    instruction fetch request
//   pcWEN      PC write enable
//   halted     sticky halted status
//   stall_cnt  cycles the current data request has waited (saturating)
//   timeout    stall_cnt has reached MAX_WAIT
//
// Optional build macro MEM_REQUEST_UNIT_PERF_EN adds two free-running
// performance counters:
//   perf_ifetch  rising edges with pcWEN high
//   perf_dreq    completed data requests
// Both wrap modulo 2**32 and freeze once halted.

module mem_request_unit #(
  parameter int unsigned WAIT_W             = 8,
  parameter int unsigned MAX_WAIT           = 200,
  parameter bit          IFETCH_DURING_DATA = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              halt,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              ihit,
  input  logic              dhit,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              imemREN,
  output logic              pcWEN,
  output logic              halted,
  output logic [WAIT_W-1:0] stall_cnt,
  output logic              timeout
`ifdef MEM_REQUEST_UNIT_PERF_EN
  ,
  output logic [31:0]       perf_ifetch,
  output logic [31:0]       perf_dreq
`endif
);

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    StIdle,
    StDwait,
    StDrain,
    StHalted
  } state_e;

  state_e            state_q, state_d;
  logic              dmem_ren_q, dmem_ren_d;
  logic              dmem_wen_q, dmem_wen_d;
  logic [WAIT_W-1:0] stall_q, stall_d;
  logic              timeout_q, timeout_d;
  logic              pend;

  assign pend = (state_q == StDwait) || (state_q == StDrain);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    dmem_ren_d = dmem_ren_q;
    dmem_wen_d = dmem_wen_q;
    stall_d    = stall_q;

    unique case (state_q)
      StIdle: begin
        // dhit here is a spurious acknowledge and is ignored.
        if (ihit && halt) begin
          state_d = StHalted;
        end else if (ihit && (dREN || dWEN)) begin
          state_d    = StDwait;
          // Write wins when both enables are set.
          dmem_wen_d = dWEN;
          dmem_ren_d = dREN & ~dWEN;
        end
      end

      StDwait, StDrain: begin
        // ihit is ignored while a request is pending; nothing is queued.
        if (dhit) begin
          // A halt arriving together with the acknowledge lets the request
          // complete and halts straight away.
          state_d    = ((state_q == StDrain) || halt) ? StHalted : StIdle;
          dmem_ren_d = 1'b0;
          dmem_wen_d = 1'b0;
          stall_d    = '0;
        end else begin
          if (halt) begin
            state_d = StDrain;
          end
          if (stall_q != MaxWait) begin
            stall_d = stall_q + 1'b1;
          end
        end
      end

      StHalted: begin
        dmem_ren_d = 1'b0;
        dmem_wen_d = 1'b0;
        stall_d    = '0;
      end

      default: begin
        state_d    = StIdle;
        dmem_ren_d = 1'b0;
        dmem_wen_d = 1'b0;
        stall_d    = '0;
      end
    endcase

    // Watchdog only reports; it never changes the FSM.
    timeout_d = (stall_d == MaxWait);
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      dmem_ren_q <= 1'b0;
      dmem_wen_q <= 1'b0;
      stall_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dmem_ren_q <= dmem_ren_d;
      dmem_wen_q <= dmem_wen_d;
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
    end
  end

  // Combinational outputs
  always_comb begin
    imemREN = 1'b1;
    pcWEN   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Only instructions without data traffic advance the PC directly.
        pcWEN = ihit & ~halt & ~dREN & ~dWEN;
      end
      StDwait: begin
        imemREN = IFETCH_DURING_DATA;
        pcWEN   = dhit & ~halt;
      end
      StDrain: begin
        imemREN = IFETCH_DURING_DATA;
      end
      StHalted: begin
        imemREN = 1'b0;
      end
      default: begin
        imemREN = 1'b1;
      end
    endcase

    // Hold the PC while reset is asserted, whatever the cache inputs do.
    pcWEN = pcWEN & nRST;
  end

  assign dmemREN   = dmem_ren_q;
  assign dmemWEN   = dmem_wen_q;
  assign halted    = (state_q == StHalted);
  assign stall_cnt = stall_q;
  assign timeout   = timeout_q;

`ifdef MEM_REQUEST_UNIT_PERF_EN
  logic [31:0] perf_ifetch_q, perf_dreq_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_ifetch_q <= '0;
      perf_dreq_q   <= '0;
    end else if (state_q != StHalted) begin
      if (pcWEN) begin
        perf_ifetch_q <= perf_ifetch_q + 32'd1;
      end
      if (pend && dhit) begin
        perf_dreq_q <= perf_dreq_q + 32'd1;
      end
    end
  end

  assign perf_ifetch = perf_ifetch_q;
  assign perf_dreq   = perf_dreq_q;
`endif

endmodule
